// File: rtl/conway_pkg.sv
// rtl/conway_pkg.sv - shared types, constants and helpers for the conway display scanner
package conway_pkg;

    // Scanner sequencing: idle, snapshot the board, inter-row blanking, row lit.
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_BLANK,
        S_SHOW
    } scan_state_t;

    // Width of the PWM phase counter used by the dimming build.
    localparam int PWM_W = 4;

    // Widest row-select vector onehot() can produce.
    localparam int ONEHOT_MAX = 64;

    // One-hot decode of idx; all-zero when idx lies outside [0, width).
    function automatic logic [ONEHOT_MAX-1:0] onehot(input int idx, input int width);
        logic [ONEHOT_MAX-1:0] v;
        v = '0;
        for (int i = 0; i < ONEHOT_MAX; i++) begin
            v[i] = (i == idx) && (i < width);
        end
        return v;
    endfunction

endpackage

// File: rtl/conway_scan_timer.sv
// rtl/conway_scan_timer.sv - loadable down-counter timing the blank and dwell intervals
module conway_scan_timer #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_done
);

    logic [W-1:0] r_count;

    // Loading value v makes o_done rise after v further cycles, so an
    // interval of L cycles is started by loading L-1 on entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/conway_display_scanner.sv
// rtl/conway_display_scanner.sv - row-multiplexed LED scanner for the conway board (CONWAY_SCAN_DIM_EN adds PWM dimming)
module conway_display_scanner
    import conway_pkg::*;
#(
    parameter int N     = 8,
    parameter int DWELL = 1000,
    parameter int BLANK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [N*N-1:0]   board,
`ifdef CONWAY_SCAN_DIM_EN
    input  logic [PWM_W-1:0] brightness,
`endif
    output logic [N-1:0]     rows,
    output logic [N-1:0]     cols,
    output logic             frame_done
);

    localparam int RW   = (N > 1) ? $clog2(N) : 1;
    localparam int TMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LD = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    // Each row starts with blanking, or goes straight to lit when blanking is disabled.
    localparam scan_state_t   FIRST_ST = (BLANK > 0) ? S_BLANK : S_SHOW;
    localparam logic [CW-1:0] FIRST_LD = (BLANK > 0) ? BLANK_LD : DWELL_LD;

    scan_state_t    r_state;
    scan_state_t    w_nxt_state;
    logic [RW-1:0]  r_row;
    logic [RW-1:0]  w_nxt_row;
    logic [N*N-1:0] r_snapshot;
    logic [N*N-1:0] w_snap_nxt;
    logic [N-1:0]   r_rows;
    logic [N-1:0]   r_cols;
    logic [N-1:0]   w_rows_nxt;
    logic [N-1:0]   w_cols_nxt;
    logic [N-1:0]   w_row_data;
    logic           r_frame_done;
    logic           w_fd_nxt;
    logic           w_tmr_load;
    logic [CW-1:0]  w_tmr_val;
    logic           w_tmr_done;
    logic           w_lit;

    conway_scan_timer #(
        .W (CW)
    ) u_timer (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_val),
        .o_done  (w_tmr_done)
    );

    // Next-state decision; run=0 beats every other event and parks the scan in IDLE.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_row   = r_row;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_fd_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_nxt_state = S_LOAD;
            end
            S_LOAD: begin
                w_nxt_row   = '0;
                w_nxt_state = FIRST_ST;
                w_tmr_load  = 1'b1;
                w_tmr_val   = FIRST_LD;
            end
            S_BLANK: begin
                if (w_tmr_done) begin
                    w_nxt_state = S_SHOW;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = DWELL_LD;
                end
            end
            S_SHOW: begin
                if (w_tmr_done) begin
                    if (r_row == LAST_ROW) begin
                        // Row index only wraps back to 0 through LOAD.
                        w_nxt_state = S_LOAD;
                        w_fd_nxt    = 1'b1;
                    end else begin
                        w_nxt_row   = r_row + RW'(1);
                        w_nxt_state = FIRST_ST;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = FIRST_LD;
                    end
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
        if (!run) begin
            w_nxt_state = S_IDLE;
            w_nxt_row   = r_row;
            w_tmr_load  = 1'b0;
            w_fd_nxt    = 1'b0;
        end
    end

`ifdef CONWAY_SCAN_DIM_EN
    logic [PWM_W-1:0] r_pwm;
    logic [PWM_W-1:0] w_pwm_nxt;

    // Every entry into SHOW loads the timer, so the load strobe restarts the PWM phase.
    assign w_pwm_nxt = w_tmr_load ? '0 : r_pwm + PWM_W'(1);
    assign w_lit     = (w_pwm_nxt <= brightness);

    // PWM phase counter, wrapping freely while a row is lit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= w_pwm_nxt;
        end
    end
`else
    assign w_lit = 1'b1;
`endif

    // Decode next-cycle LED values; LOAD->SHOW without blanking takes row 0 straight from the board being captured.
    always_comb begin
        w_snap_nxt = (r_state == S_LOAD && run) ? board : r_snapshot;
        w_row_data = '0;
        for (int r = 0; r < N; r++) begin
            if (w_nxt_row == RW'(r)) begin
                w_row_data = w_snap_nxt[r*N +: N];
            end
        end
        w_rows_nxt = '0;
        w_cols_nxt = '0;
        if (w_nxt_state == S_SHOW) begin
            w_rows_nxt = N'(onehot(int'(w_nxt_row), N));
            w_cols_nxt = w_lit ? w_row_data : '0;
        end
    end

    // Scan FSM: state, row index, frame snapshot and registered LED outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_snapshot   <= '0;
            r_rows       <= '0;
            r_cols       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_row        <= w_nxt_row;
            r_snapshot   <= w_snap_nxt;
            r_rows       <= w_rows_nxt;
            r_cols       <= w_cols_nxt;
            r_frame_done <= w_fd_nxt;
        end
    end

    assign rows       = r_rows;
    assign cols       = r_cols;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conway_display_scanner.sv
// tb/tb_conway_display_scanner.sv - self-checking bench for conway_display_scanner
module tb_conway_display_scanner;

    localparam int N   = 4;
    localparam int D_A = 3;
    localparam int B_A = 1;
    localparam int D_B = 1;
    localparam int B_B = 0;

    logic           clk   = 1'b0;
    logic           rst   = 1'b0;
    logic           run   = 1'b0;
    logic [N*N-1:0] board = '0;
    logic [N-1:0]   rows_a, cols_a, rows_b, cols_b;
    logic           fd_a, fd_b;
`ifdef CONWAY_SCAN_DIM_EN
    logic [3:0]     brightness = 4'hF;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    conway_display_scanner #(.N(N), .DWELL(D_A), .BLANK(B_A)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .board      (board),
`ifdef CONWAY_SCAN_DIM_EN
        .brightness (brightness),
`endif
        .rows       (rows_a),
        .cols       (cols_a),
        .frame_done (fd_a)
    );

    conway_display_scanner #(.N(N), .DWELL(D_B), .BLANK(B_B)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .board      (board),
`ifdef CONWAY_SCAN_DIM_EN
        .brightness (brightness),
`endif
        .rows       (rows_b),
        .cols       (cols_b),
        .frame_done (fd_b)
    );

    // Reference model: position within the frame (-1 idle, 0 load, 1..N*(B+D) row slots).
    int             m_pos  [2];
    logic [N*N-1:0] m_snap [2];
    logic           m_fd   [2];

    function automatic int blank_of(int k);
        return (k == 0) ? B_A : B_B;
    endfunction

    function automatic int dwell_of(int k);
        return (k == 0) ? D_A : D_B;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pos[k]  = -1;
            m_fd[k]   = 1'b0;
            m_snap[k] = '0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int last;
            last = N * (blank_of(k) + dwell_of(k));
            m_fd[k] = 1'b0;
            if (!run) begin
                m_pos[k] = -1;
            end else if (m_pos[k] == -1) begin
                m_pos[k] = 0;
            end else if (m_pos[k] == 0) begin
                m_snap[k] = board;
                m_pos[k]  = 1;
            end else if (m_pos[k] == last) begin
                m_pos[k] = 0;
                m_fd[k]  = 1'b1;
            end else begin
                m_pos[k] = m_pos[k] + 1;
            end
        end
    endtask

    // Row lit at the model's current position, or -1 when dark.
    function automatic int lit_row(int k);
        int slot, off;
        if (m_pos[k] < 1) return -1;
        slot = blank_of(k) + dwell_of(k);
        off  = (m_pos[k] - 1) % slot;
        if (off < blank_of(k)) return -1;
        return (m_pos[k] - 1) / slot;
    endfunction

    function automatic logic [N-1:0] exp_rows(int k);
        logic [N-1:0] v;
        int r;
        v = '0;
        r = lit_row(k);
        if (r >= 0) v[r] = 1'b1;
        return v;
    endfunction

    function automatic logic [N-1:0] exp_cols(int k);
        logic [N*N-1:0] s;
        int r;
        r = lit_row(k);
        if (r < 0) return '0;
        s = m_snap[k];
        return s[r*N +: N];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_models(input string tag);
        check({tag, ".rows_a"}, 32'(rows_a), 32'(exp_rows(0)));
        check({tag, ".cols_a"}, 32'(cols_a), 32'(exp_cols(0)));
        check({tag, ".fd_a"},   32'(fd_a),   32'(m_fd[0]));
        check({tag, ".rows_b"}, 32'(rows_b), 32'(exp_rows(1)));
        check({tag, ".cols_b"}, 32'(cols_b), 32'(exp_cols(1)));
        check({tag, ".fd_b"},   32'(fd_b),   32'(m_fd[1]));
    endtask

    // One clock: predict, clock the DUTs, sample on the falling edge, compare.
    task automatic tick(input string tag);
        if (rst) model_step();
        @(posedge clk);
        @(negedge clk);
        check_models(tag);
    endtask

    typedef struct packed {
        logic           run;
        logic [N*N-1:0] board;
        logic [N-1:0]   rows;
        logic [N-1:0]   cols;
        logic           fd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [N*N-1:0] b, input logic [N-1:0] ro,
                       input logic [N-1:0] co, input logic f);
        vecs.push_back('{run: r, board: b, rows: ro, cols: co, fd: f});
    endtask

    task automatic add_show(input logic [N*N-1:0] b, input logic [N-1:0] ro, input logic [N-1:0] co);
        for (int i = 0; i < D_A; i++) add(1'b1, b, ro, co, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int last_fd;
        int fd_pulses;
        logic [31:0] rnd;

        // First frame of 8421, board switched to FFFF mid-frame, then the start of frame two.
        add(1'b1, 16'h8421, 4'h0, 4'h0, 1'b0);
        add(1'b1, 16'h8421, 4'h0, 4'h0, 1'b0);
        add_show(16'h8421, 4'h1, 4'h1);
        add(1'b1, 16'h8421, 4'h0, 4'h0, 1'b0);
        add_show(16'hFFFF, 4'h2, 4'h2);
        add(1'b1, 16'hFFFF, 4'h0, 4'h0, 1'b0);
        add_show(16'hFFFF, 4'h4, 4'h4);
        add(1'b1, 16'hFFFF, 4'h0, 4'h0, 1'b0);
        add_show(16'hFFFF, 4'h8, 4'h8);
        add(1'b1, 16'hFFFF, 4'h0, 4'h0, 1'b1);
        add(1'b1, 16'hFFFF, 4'h0, 4'h0, 1'b0);
        add_show(16'hFFFF, 4'h1, 4'hF);
        add(1'b1, 16'hFFFF, 4'h0, 4'h0, 1'b0);
        add_show(16'hFFFF, 4'h2, 4'hF);

        model_reset();
        repeat (2) @(negedge clk);
        check("reset.rows_a", 32'(rows_a), 32'h0);
        check("reset.cols_a", 32'(cols_a), 32'h0);
        check("reset.fd_a",   32'(fd_a),   32'h0);
        check("reset.rows_b", 32'(rows_b), 32'h0);
        rst = 1'b1;

        last_fd   = -1;
        fd_pulses = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            run   = vecs[i].run;
            board = vecs[i].board;
            tick($sformatf("vec%0d", i));
            check($sformatf("vec%0d.rows", i), 32'(rows_a), 32'(vecs[i].rows));
            check($sformatf("vec%0d.cols", i), 32'(cols_a), 32'(vecs[i].cols));
            check($sformatf("vec%0d.fd", i),   32'(fd_a),   32'(vecs[i].fd));
            if (fd_b) begin
                if (last_fd >= 0) check("fd_b.period", 32'(i - last_fd), 32'd5);
                last_fd = i;
                fd_pulses++;
            end
        end
        check("fd_b.pulses", 32'(fd_pulses), 32'd5);

        // run dropped during row 2: dark at once, no frame_done, restart at row 0.
        tick("pre_row2");
        tick("row2");
        check("row2.rows", 32'(rows_a), 32'h4);
        run = 1'b0;
        tick("stop");
        check("stop.rows", 32'(rows_a), 32'h0);
        check("stop.cols", 32'(cols_a), 32'h0);
        check("stop.fd",   32'(fd_a),   32'h0);
        tick("idle");
        check("idle.rows", 32'(rows_a), 32'h0);
        run = 1'b1;
        tick("restart_load");
        check("restart_load.rows", 32'(rows_a), 32'h0);
        check("restart_load.fd",   32'(fd_a),   32'h0);
        tick("restart_blank");
        tick("restart_row0");
        check("restart_row0.rows", 32'(rows_a), 32'h1);
        check("restart_row0.cols", 32'(cols_a), 32'hF);

        // Asynchronous reset between edges blanks immediately; LOAD follows the first edge after release.
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("async.rows_a", 32'(rows_a), 32'h0);
        check("async.cols_a", 32'(cols_a), 32'h0);
        check("async.rows_b", 32'(rows_b), 32'h0);
        check("async.cols_b", 32'(cols_b), 32'h0);
        tick("in_reset");
        rst = 1'b1;
        tick("post_reset_load");
        check("post_reset_load.rows", 32'(rows_a), 32'h0);
        tick("post_reset_blank");
        tick("post_reset_row0");
        check("post_reset_row0.rows", 32'(rows_a), 32'h1);

        // Randomised run/board traffic with occasional asynchronous resets.
        for (int c = 0; c < 2500; c++) begin
            rnd   = $urandom();
            board = rnd[N*N-1:0];
            if (run) run = ($urandom_range(0, 39) != 0);
            else     run = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b0;
                #1;
                model_reset();
                check("rnd_async.rows_a", 32'(rows_a), 32'h0);
                check("rnd_async.cols_b", 32'(cols_b), 32'h0);
                tick("rnd_reset");
                rst = 1'b1;
            end else begin
                tick("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
